// File: rtl/xillybus_spi_bridge_if.sv
// ---------------------------------------------------------------------------
// xillybus_spi_bridge_if
//
// Purpose: bundles the Xillybus user-side stream pair for the "spi" device
// file. The write stream carries command words from the host into the
// bridge. The read stream carries response words from the bridge back to
// the host.
//
// Signals:
//   user_w_write_spi_data_w   command word from the host
//   user_w_write_spi_wren_w   write strobe
//   user_w_write_spi_open_w   host has the write file open
//   user_w_write_spi_full_w   bridge TX FIFO full
//   user_r_read_spi_rden_w    read strobe
//   user_r_read_spi_open_w    host has the read file open
//   user_r_read_spi_data_w    response word
//   user_r_read_spi_empty_w   bridge RX FIFO empty
//   user_r_read_spi_eof_w     end of stream
//
// Modports:
//   master  the core side, which drives the strobes and open flags
//   slave   the bridge side, which drives full, data, empty and eof
// ---------------------------------------------------------------------------
interface xillybus_spi_bridge_if;
  logic [31:0] user_w_write_spi_data_w;
  logic        user_w_write_spi_wren_w;
  logic        user_w_write_spi_open_w;
  logic        user_w_write_spi_full_w;
  logic        user_r_read_spi_rden_w;
  logic        user_r_read_spi_open_w;
  logic [31:0] user_r_read_spi_data_w;
  logic        user_r_read_spi_empty_w;
  logic        user_r_read_spi_eof_w;

  modport master (
    output user_w_write_spi_data_w, user_w_write_spi_wren_w,
           user_w_write_spi_open_w, user_r_read_spi_rden_w,
           user_r_read_spi_open_w,
    input  user_w_write_spi_full_w, user_r_read_spi_data_w,
           user_r_read_spi_empty_w, user_r_read_spi_eof_w
  );

  modport slave (
    input  user_w_write_spi_data_w, user_w_write_spi_wren_w,
           user_w_write_spi_open_w, user_r_read_spi_rden_w,
           user_r_read_spi_open_w,
    output user_w_write_spi_full_w, user_r_read_spi_data_w,
           user_r_read_spi_empty_w, user_r_read_spi_eof_w
  );
endinterface

// File: rtl/xillybus_spi_bridge.sv
// ---------------------------------------------------------------------------
// xillybus_spi_bridge
//
// Purpose: the user-side endpoint of the Xillybus "spi" stream pair. The
// bridge takes command words from the host, queues them in a TX FIFO, and
// runs each one as an SPI mode-0 byte transfer (MSB first). When a command
// asks for a response, the received byte is queued in an RX FIFO as
// {24'h0, rx_byte}.
//
// Command word layout:
//   [7:0] TX byte
//   [8]   LAST, which releases CS after this byte
//   [9]   NORESP, which discards the received byte
//
// Ports:
//   bus_clk_w      single clock; all logic is on its rising edge
//   trn_reset_n_w  asynchronous, active-low reset
//   bus            Xillybus stream signals (slave modport)
//   spi_sck        SPI clock output
//   spi_cs_n       SPI chip select output
//   spi_mosi       SPI data output
//   spi_miso       SPI data input, double-flop synchronised
//
// Parameters:
//   CLK_DIV     SCK half-period in clock cycles (>= 2)
//   DEPTH_LOG2  log2 of the depth of each FIFO
// ---------------------------------------------------------------------------
module xillybus_spi_bridge #(
  parameter int CLK_DIV    = 4,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  bus_clk_w,
  input  logic                  trn_reset_n_w,
  xillybus_spi_bridge_if.slave  bus,
  output logic                  spi_sck,
  output logic                  spi_cs_n,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int DIV_W = $clog2(CLK_DIV);

  typedef logic [DEPTH_LOG2:0]   cnt_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  typedef enum logic [2:0] {
    IDLE, SETUP, SCK_LO, SCK_HI, NEXT, CS_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              last_q, last_d;
  logic              noresp_q, noresp_d;
  logic              inflight_q, inflight_d;
  logic              sck_q, sck_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              miso_meta_q, miso_meta_d;
  logic              miso_sync_q, miso_sync_d;
  ptr_t              tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  cnt_t              tx_count_q, tx_count_d;
  logic              full_q, full_d;
  ptr_t              rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  cnt_t              rx_count_q, rx_count_d;
  logic              empty_q, empty_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              eof_armed_q, eof_armed_d;
  logic              eof_q, eof_d;

  logic [9:0]        tx_mem [DEPTH];
  logic [7:0]        rx_mem [DEPTH];

  logic              tx_wr, tx_rd, rx_push, rx_pop;
  logic              div_end, start_ok, do_start;
  logic [9:0]        tx_head;
  logic [DEPTH_LOG2+1:0] rx_committed;
  logic              unused_cmd_bits;

  // Command bits above NORESP carry no meaning here.
  assign unused_cmd_bits = ^bus.user_w_write_spi_data_w[31:10];

  assign tx_head = tx_mem[tx_rd_ptr_q];
  assign div_end = (div_q == DIV_W'(CLK_DIV - 1));

  // Responses already held plus the one in flight must leave room, so a
  // started transfer always has a free RX slot when its byte completes.
  assign rx_committed = {1'b0, rx_count_q} + {{(DEPTH_LOG2 + 1){1'b0}}, inflight_q};
  assign start_ok = (tx_count_q != '0) &&
                    (tx_head[9] || (rx_committed < (DEPTH_LOG2 + 2)'(DEPTH)));

  // FIFO storage has no reset; only the pointers and counts need one.
  always_ff @(posedge bus_clk_w) begin
    if (tx_wr) tx_mem[tx_wr_ptr_q] <= bus.user_w_write_spi_data_w[9:0];
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_shift_q;
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    last_d      = last_q;
    noresp_d    = noresp_q;
    inflight_d  = inflight_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    miso_meta_d = spi_miso;
    miso_sync_d = miso_meta_q;
    tx_rd       = 1'b0;
    rx_push     = 1'b0;
    do_start    = 1'b0;

    case (state_q)
      IDLE: do_start = start_ok;
      SETUP, SCK_LO: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          sck_d      = 1'b1;
          rx_shift_d = {rx_shift_q[6:0], miso_sync_q};
          state_d    = SCK_HI;
        end
      end
      SCK_HI: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          sck_d = 1'b0;
          if (bit_cnt_q != 3'd7) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            mosi_d     = tx_shift_q[6];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            state_d    = SCK_LO;
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        rx_push    = !noresp_q && bus.user_r_read_spi_open_w;
        inflight_d = 1'b0;
        if (last_q) begin
          cs_n_d  = 1'b1;
          div_d   = '0;
          state_d = CS_GAP;
        end else if (start_ok) begin
          do_start = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CS_GAP: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Starting a byte is the same whether CS was already low or not.
    if (do_start) begin
      tx_rd      = 1'b1;
      cs_n_d     = 1'b0;
      tx_shift_d = tx_head[7:0];
      mosi_d     = tx_head[7];
      last_d     = tx_head[8];
      noresp_d   = tx_head[9];
      inflight_d = !tx_head[9];
      bit_cnt_d  = '0;
      div_d      = '0;
      state_d    = SETUP;
    end
  end

  // FIFO bookkeeping. Closing the read file flushes the RX side.
  always_comb begin
    tx_wr       = bus.user_w_write_spi_wren_w && !full_q;
    tx_wr_ptr_d = tx_wr_ptr_q + ptr_t'(tx_wr);
    tx_rd_ptr_d = tx_rd_ptr_q + ptr_t'(tx_rd);
    tx_count_d  = tx_count_q + cnt_t'(tx_wr) - cnt_t'(tx_rd);
    full_d      = (tx_count_d == cnt_t'(DEPTH));

    rx_pop  = bus.user_r_read_spi_rden_w && !empty_q && bus.user_r_read_spi_open_w;
    rdata_d = rx_pop ? {24'h0, rx_mem[rx_rd_ptr_q]} : rdata_q;
    if (!bus.user_r_read_spi_open_w) begin
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_count_d  = '0;
    end else begin
      rx_wr_ptr_d = rx_wr_ptr_q + ptr_t'(rx_push);
      rx_rd_ptr_d = rx_rd_ptr_q + ptr_t'(rx_pop);
      rx_count_d  = rx_count_q + cnt_t'(rx_push) - cnt_t'(rx_pop);
    end
    empty_d = (rx_count_d == '0);

    eof_armed_d = eof_armed_q || bus.user_w_write_spi_open_w;
    eof_d = eof_armed_q && !bus.user_w_write_spi_open_w && (tx_count_q == '0) &&
            (state_q == IDLE) && cs_n_q && (rx_count_q == '0);
  end

  always_ff @(posedge bus_clk_w or negedge trn_reset_n_w) begin
    if (!trn_reset_n_w) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      last_q      <= 1'b0;
      noresp_q    <= 1'b0;
      inflight_q  <= 1'b0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      full_q      <= 1'b0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      empty_q     <= 1'b1;
      rdata_q     <= '0;
      eof_armed_q <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      last_q      <= last_d;
      noresp_q    <= noresp_d;
      inflight_q  <= inflight_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      miso_meta_q <= miso_meta_d;
      miso_sync_q <= miso_sync_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      full_q      <= full_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      empty_q     <= empty_d;
      rdata_q     <= rdata_d;
      eof_armed_q <= eof_armed_d;
      eof_q       <= eof_d;
    end
  end

  assign spi_sck  = sck_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

  assign bus.user_w_write_spi_full_w  = full_q;
  assign bus.user_r_read_spi_data_w   = rdata_q;
  assign bus.user_r_read_spi_empty_w  = empty_q;
  assign bus.user_r_read_spi_eof_w    = eof_q;

endmodule

// File: tb/tb_xillybus_spi_bridge.sv
// ---------------------------------------------------------------------------
// tb_xillybus_spi_bridge
//
// Directed bench for the SPI bridge. A small SPI slave model drives MISO
// with a known byte sequence: byte n of a test is 8'h3C + 17*n. It shifts
// one bit out on every falling SCK edge. Monitors count SCK edges and CS
// releases, and they collect the MOSI bits seen on each rising SCK edge.
// ---------------------------------------------------------------------------
module tb_xillybus_spi_bridge;

  localparam int CLK_DIV = 4;

  logic bus_clk_w = 1'b0;
  logic trn_reset_n_w;
  logic spi_sck, spi_cs_n, spi_mosi, spi_miso;

  xillybus_spi_bridge_if bus_if();

  xillybus_spi_bridge #(.CLK_DIV(CLK_DIV), .DEPTH_LOG2(4)) dut (
    .bus_clk_w     (bus_clk_w),
    .trn_reset_n_w (trn_reset_n_w),
    .bus           (bus_if),
    .spi_sck       (spi_sck),
    .spi_cs_n      (spi_cs_n),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso)
  );

  always #5 bus_clk_w = ~bus_clk_w;

  int num_checks = 0;
  int num_fail = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int cs_rise_cnt = 0;
  int fall_base = 0;
  logic [31:0] mosi_hist = '0;
  int miso_rel;
  logic [7:0] miso_byte;

  function automatic logic [7:0] miso_pat(input int n);
    return 8'h3C + 8'(n * 17);
  endfunction

  // Count SCK edges and collect the MOSI bit on each rising edge.
  always @(posedge spi_sck) begin
    rise_cnt++;
    mosi_hist = {mosi_hist[30:0], spi_mosi};
  end

  always @(negedge spi_sck) fall_cnt++;

  always @(posedge spi_cs_n) cs_rise_cnt++;

  // The slave model shifts the current byte out MSB first; every eighth
  // falling edge moves it to the next byte of the sequence.
  always_comb begin
    miso_rel  = fall_cnt - fall_base;
    miso_byte = miso_pat(miso_rel / 8);
    spi_miso  = miso_byte[3'(7 - (miso_rel % 8))];
  end

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge bus_clk_w);
  endtask

  task automatic write_word(input logic [31:0] w);
    bus_if.user_w_write_spi_data_w = w;
    bus_if.user_w_write_spi_wren_w = 1'b1;
    @(negedge bus_clk_w);
    bus_if.user_w_write_spi_wren_w = 1'b0;
  endtask

  task automatic pop_word(input string tag, input logic [7:0] expected);
    bus_if.user_r_read_spi_rden_w = 1'b1;
    @(negedge bus_clk_w);
    bus_if.user_r_read_spi_rden_w = 1'b0;
    check_output(tag, bus_if.user_r_read_spi_data_w, {24'h0, expected});
  endtask

  task automatic wait_rises(input string tag, input int target);
    for (int i = 0; i < 4000 && rise_cnt < target; i++) @(negedge bus_clk_w);
    check_output(tag, rise_cnt, target);
  endtask

  task automatic wait_cs_high(input string tag);
    for (int i = 0; i < 2000 && spi_cs_n !== 1'b1; i++) @(negedge bus_clk_w);
    check_output(tag, {31'h0, spi_cs_n}, 32'h1);
  endtask

  task automatic start_test(output int rb, output int cb);
    fall_base = fall_cnt;
    rb = rise_cnt;
    cb = cs_rise_cnt;
  endtask

  initial begin
    int rb, cb;
    trn_reset_n_w = 1'b0;
    bus_if.user_w_write_spi_data_w = '0;
    bus_if.user_w_write_spi_wren_w = 1'b0;
    bus_if.user_w_write_spi_open_w = 1'b0;
    bus_if.user_r_read_spi_rden_w  = 1'b0;
    bus_if.user_r_read_spi_open_w  = 1'b0;
    idle_cycles(3);

    // Reset values
    check_output("rst_full",  {31'h0, bus_if.user_w_write_spi_full_w}, 32'h0);
    check_output("rst_empty", {31'h0, bus_if.user_r_read_spi_empty_w}, 32'h1);
    check_output("rst_eof",   {31'h0, bus_if.user_r_read_spi_eof_w}, 32'h0);
    check_output("rst_data",  bus_if.user_r_read_spi_data_w, 32'h0);
    check_output("rst_sck",   {31'h0, spi_sck}, 32'h0);
    check_output("rst_cs_n",  {31'h0, spi_cs_n}, 32'h1);
    check_output("rst_mosi",  {31'h0, spi_mosi}, 32'h0);

    trn_reset_n_w = 1'b1;
    bus_if.user_w_write_spi_open_w = 1'b1;
    bus_if.user_r_read_spi_open_w  = 1'b1;
    idle_cycles(2);

    // Single byte A5 with LAST: write, then pop, then CS falls
    start_test(rb, cb);
    write_word(32'h1A5);
    check_output("lat_after_write", {31'h0, spi_cs_n}, 32'h1);
    idle_cycles(1);
    check_output("lat_after_pop", {31'h0, spi_cs_n}, 32'h0);
    wait_cs_high("t1_cs_release");
    check_output("t1_sck_pulses", rise_cnt - rb, 8);
    check_output("t1_mosi", {24'h0, mosi_hist[7:0]}, 32'hA5);
    check_output("t1_cs_rises", cs_rise_cnt - cb, 1);
    check_output("t1_not_empty", {31'h0, bus_if.user_r_read_spi_empty_w}, 32'h0);
    pop_word("t1_resp", 8'h3C);
    check_output("t1_empty_after", {31'h0, bus_if.user_r_read_spi_empty_w}, 32'h1);
    idle_cycles(CLK_DIV + 4);

    // Three chained bytes under one CS assertion
    start_test(rb, cb);
    write_word(32'h011);
    write_word(32'h022);
    write_word(32'h133);
    wait_cs_high("t2_cs_release");
    idle_cycles(8);
    check_output("t2_sck_pulses", rise_cnt - rb, 24);
    check_output("t2_mosi", {8'h0, mosi_hist[23:0]}, 32'h112233);
    check_output("t2_cs_rises", cs_rise_cnt - cb, 1);
    pop_word("t2_resp0", 8'h3C);
    pop_word("t2_resp1", 8'h4D);
    pop_word("t2_resp2", 8'h5E);
    check_output("t2_empty_after", {31'h0, bus_if.user_r_read_spi_empty_w}, 32'h1);

    // NORESP byte followed by a normal byte: only the second responds
    start_test(rb, cb);
    write_word(32'h2FF);
    write_word(32'h100);
    wait_cs_high("t3_cs_release");
    idle_cycles(8);
    check_output("t3_mosi", {16'h0, mosi_hist[15:0]}, 32'hFF00);
    check_output("t3_not_empty", {31'h0, bus_if.user_r_read_spi_empty_w}, 32'h0);
    pop_word("t3_resp", 8'h4D);
    check_output("t3_empty_after", {31'h0, bus_if.user_r_read_spi_empty_w}, 32'h1);

    // Backpressure. In a 20-word burst, word 0 is popped at once, words 1-16
    // fill the TX FIFO and the rest are dropped.
    start_test(rb, cb);
    for (int i = 0; i < 20; i++) begin
      bus_if.user_w_write_spi_data_w = 32'h100 | 32'(i);
      bus_if.user_w_write_spi_wren_w = 1'b1;
      @(negedge bus_clk_w);
      if (i == 15)
        check_output("bp_not_full_15", {31'h0, bus_if.user_w_write_spi_full_w}, 32'h0);
    end
    bus_if.user_w_write_spi_wren_w = 1'b0;
    check_output("bp_full", {31'h0, bus_if.user_w_write_spi_full_w}, 32'h1);
    wait_rises("bp_16_done", rb + 128);
    idle_cycles(300);
    check_output("bp_stall", rise_cnt - rb, 128);
    check_output("bp_mosi_15", {24'h0, mosi_hist[7:0]}, 32'h0F);
    check_output("bp_full_clear", {31'h0, bus_if.user_w_write_spi_full_w}, 32'h0);
    write_word(32'h1E0);
    write_word(32'h1E1);
    idle_cycles(300);
    check_output("bp_hold", rise_cnt - rb, 128);
    pop_word("bp_pop0", miso_pat(0));
    wait_rises("bp_17_done", rb + 136);
    idle_cycles(300);
    check_output("bp_one_more", rise_cnt - rb, 136);
    check_output("bp_mosi_16", {24'h0, mosi_hist[7:0]}, 32'h10);

    // Pop so the next byte runs, then pop again in the same cycle its
    // response is pushed.
    pop_word("bp_pop1", miso_pat(1));
    for (int i = 0; i < 2000 && rise_cnt != rb + 144; i++) begin
      @(posedge bus_clk_w);
      #1;
    end
    check_output("bp_sync_rises", rise_cnt - rb, 144);
    repeat (4) @(posedge bus_clk_w);
    #1 bus_if.user_r_read_spi_rden_w = 1'b1;
    @(posedge bus_clk_w);
    #1 bus_if.user_r_read_spi_rden_w = 1'b0;
    check_output("bp_pop_push", bus_if.user_r_read_spi_data_w, {24'h0, miso_pat(2)});
    @(negedge bus_clk_w);
    wait_rises("bp_19_done", rb + 152);
    idle_cycles(300);
    check_output("bp_final_rises", rise_cnt - rb, 152);
    check_output("bp_mosi_e1", {24'h0, mosi_hist[7:0]}, 32'hE1);
    for (int n = 3; n < 19; n++) pop_word($sformatf("bp_drain%0d", n), miso_pat(n));
    check_output("bp_drained", {31'h0, bus_if.user_r_read_spi_empty_w}, 32'h1);

    // A read strobe on an empty FIFO leaves data alone
    bus_if.user_r_read_spi_rden_w = 1'b1;
    idle_cycles(1);
    bus_if.user_r_read_spi_rden_w = 1'b0;
    idle_cycles(1);
    check_output("rd_empty_hold", bus_if.user_r_read_spi_data_w, {24'h0, miso_pat(18)});

    // EOF: close write with two commands queued
    start_test(rb, cb);
    write_word(32'h155);
    write_word(32'h166);
    bus_if.user_w_write_spi_open_w = 1'b0;
    wait_rises("eof_rises", rb + 16);
    idle_cycles(20);
    check_output("eof_rx_pending", {31'h0, bus_if.user_r_read_spi_eof_w}, 32'h0);
    pop_word("eof_resp0", miso_pat(0));
    idle_cycles(2);
    check_output("eof_one_left", {31'h0, bus_if.user_r_read_spi_eof_w}, 32'h0);
    pop_word("eof_resp1", miso_pat(1));
    idle_cycles(2);
    check_output("eof_set", {31'h0, bus_if.user_r_read_spi_eof_w}, 32'h1);
    bus_if.user_w_write_spi_open_w = 1'b1;
    idle_cycles(2);
    check_output("eof_clear", {31'h0, bus_if.user_r_read_spi_eof_w}, 32'h0);

    // Closing the read file flushes held responses
    start_test(rb, cb);
    write_word(32'h177);
    write_word(32'h188);
    write_word(32'h199);
    wait_rises("rc_rises", rb + 24);
    idle_cycles(20);
    check_output("rc_not_empty", {31'h0, bus_if.user_r_read_spi_empty_w}, 32'h0);
    bus_if.user_r_read_spi_open_w = 1'b0;
    idle_cycles(2);
    check_output("rc_flushed", {31'h0, bus_if.user_r_read_spi_empty_w}, 32'h1);
    bus_if.user_r_read_spi_open_w = 1'b1;
    idle_cycles(2);
    check_output("rc_reopen_empty", {31'h0, bus_if.user_r_read_spi_empty_w}, 32'h1);

    // Reset in the middle of a byte, while SCK is high and MOSI is 1
    start_test(rb, cb);
    write_word(32'h0FF);
    wait_rises("mr_rises", rb + 3);
    trn_reset_n_w = 1'b0;
    #1;
    check_output("mr_sck",   {31'h0, spi_sck}, 32'h0);
    check_output("mr_cs_n",  {31'h0, spi_cs_n}, 32'h1);
    check_output("mr_mosi",  {31'h0, spi_mosi}, 32'h0);
    check_output("mr_data",  bus_if.user_r_read_spi_data_w, 32'h0);
    check_output("mr_empty", {31'h0, bus_if.user_r_read_spi_empty_w}, 32'h1);
    idle_cycles(2);
    trn_reset_n_w = 1'b1;
    idle_cycles(20);
    check_output("mr_no_resume", rise_cnt - rb, 3);
    check_output("mr_cs_idle", {31'h0, spi_cs_n}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
